// File: rtl/gcn_pkg.sv
// Shared types for the GCN adjacency aggregation stage.
// Holds the row accumulator state encoding and the default element width.
package gcn_pkg;

    localparam int DEF_DOT_PROD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/col_adder.sv
// One-column unsigned adder with carry-out overflow flag; clips to all-ones under ROW_ACCUM_SAT_EN.
// Latency: combinational.
// Backpressure: none, pure datapath.
module col_adder
    import gcn_pkg::*;
#(
    parameter int WIDTH = DEF_DOT_PROD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        ovf = raw[WIDTH];
`ifdef ROW_ACCUM_SAT_EN
        sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
        sum = raw[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/row_accumulator.sv
// Sums a group of product rows column-wise and emits one registered row per group; saturating add under ROW_ACCUM_SAT_EN.
// Latency: result valid the cycle after the closing beat is accepted.
// Backpressure: in_ready low while a result waits in HOLD; out_ready low holds the result indefinitely.
module row_accumulator
    import gcn_pkg::*;
#(
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
    parameter int MAX_ROWS       = 6,
    parameter int COUNT_WIDTH    = $clog2(MAX_ROWS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [DOT_PROD_WIDTH-1:0] in_row [0:WEIGHT_COLS-1],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DOT_PROD_WIDTH-1:0] out_row [0:WEIGHT_COLS-1],
    output logic [COUNT_WIDTH-1:0]    out_count,
    output logic                      out_trunc,
    output logic                      out_ovf
);

    state_t                    state_q, state_d;
    logic [DOT_PROD_WIDTH-1:0] acc_q [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] acc_d [0:WEIGHT_COLS-1];
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      trunc_q, trunc_d;
    logic                      ovf_q, ovf_d;

    logic [DOT_PROD_WIDTH-1:0] add_a   [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] col_sum [0:WEIGHT_COLS-1];
    logic [WEIGHT_COLS-1:0]    col_ovf;
    logic                      grp_ovf;
    logic                      unused_col_ovf;
    logic                      accept;
    logic                      closing;
    logic [COUNT_WIDTH-1:0]    count_nxt;

    // First row of a group loads straight through: feed zero to the adders.
    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            add_a[c] = (state_q == IDLE) ? '0 : acc_q[c];
        end
    end

    for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_col
        col_adder #(
            .WIDTH(DOT_PROD_WIDTH)
        ) u_col_adder (
            .a   (add_a[c]),
            .b   (in_row[c]),
            .sum (col_sum[c]),
            .ovf (col_ovf[c])
        );
    end

`ifdef ROW_ACCUM_SAT_EN
    assign grp_ovf = |col_ovf;
`else
    assign grp_ovf = 1'b0;
`endif
    assign unused_col_ovf = |col_ovf;

    assign in_ready  = (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign count_nxt = (state_q == IDLE) ? COUNT_WIDTH'(1) : count_q + COUNT_WIDTH'(1);
    assign closing   = in_last || (count_nxt == COUNT_WIDTH'(MAX_ROWS));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        trunc_d = trunc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = col_sum;
                    count_d = count_nxt;
                    trunc_d = closing && !in_last;
                    ovf_d   = ovf_q | grp_ovf;
                    state_d = closing ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    for (int c = 0; c < WEIGHT_COLS; c++) begin
                        acc_d[c] = '0;
                    end
                    count_d = '0;
                    trunc_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                acc_q[c] <= '0;
            end
            count_q <= '0;
            trunc_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_row   = acc_q;
    assign out_count = count_q;
    assign out_trunc = trunc_q;
`ifdef ROW_ACCUM_SAT_EN
    assign out_ovf   = ovf_q;
`else
    assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_row_accumulator.sv
// Scoreboard bench for row_accumulator: directed groups push expected rows, a negedge monitor pops on each handshake.
module tb_row_accumulator;

    localparam int COLS = 3;
    localparam int W    = 16;
    localparam int MAXR = 6;
    localparam int CW   = $clog2(MAXR + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [W-1:0]  in_row [0:COLS-1];
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_row [0:COLS-1];
    logic [CW-1:0] out_count;
    logic          out_trunc;
    logic          out_ovf;

    typedef struct packed {
        logic [W-1:0] r0;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [7:0]   cnt;
        logic         trunc;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    row_accumulator #(
        .WEIGHT_COLS(COLS),
        .DOT_PROD_WIDTH(W),
        .MAX_ROWS(MAXR),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_count (out_count),
        .out_trunc (out_trunc),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_out(input int a, input int b, input int c, input int cnt,
                              input bit tr, input bit ov);
        exp_t e;
        e.r0 = W'(a); e.r1 = W'(b); e.r2 = W'(c);
        e.cnt = 8'(cnt); e.trunc = tr; e.ovf = ov;
        sb.push_back(e);
    endtask

    // Drives one row; returns at accept edge + 1.
    task automatic send(input int a, input int b, input int c, input bit last);
        bit rdy;
        int k;
        in_valid  = 1'b1;
        in_last   = last;
        in_row[0] = W'(a);
        in_row[1] = W'(b);
        in_row[2] = W'(c);
        rdy = 1'b0;
        k = 0;
        while (!rdy && k < 100) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            k++;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!rdy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 100 cycles");
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_row0"}, out_row[0], 0);
        check({tag, "_row1"}, out_row[1], 0);
        check({tag, "_row2"}, out_row[2], 0);
        check({tag, "_count"}, out_count, 0);
        check({tag, "_trunc"}, out_trunc, 0);
        check({tag, "_ovf"}, out_ovf, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL mon_unexpected: got output count %0d expected no output", out_count);
            end else begin
                mon_e = sb.pop_front();
                check("mon_row0", out_row[0], mon_e.r0);
                check("mon_row1", out_row[1], mon_e.r1);
                check("mon_row2", out_row[2], mon_e.r2);
                check("mon_count", out_count, mon_e.cnt);
                check("mon_trunc", out_trunc, mon_e.trunc);
                check("mon_ovf", out_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        in_row[0] = '0; in_row[1] = '0; in_row[2] = '0;

        // Reset state
        #12;
        check_zero_outputs("reset");
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", in_ready, 1);

        // Three-row group, out_valid exactly one cycle after closing accept
        send(1, 2, 3, 0);
        send(4, 5, 6, 0);
        check("t1_no_early_valid", out_valid, 0);
        expect_out(12, 15, 18, 3, 0, 0);
        send(7, 8, 9, 1);
        check("t1_latency_valid", out_valid, 1);
        check("t1_in_ready_hold", in_ready, 0);
        @(posedge clk); #1;
        check("t1_hold_one_cycle", out_valid, 0);
        check("t1_in_ready_back", in_ready, 1);
        wait_drain();

        // Single-row group, then a group that must not include it
        expect_out(5, 0, 65535, 1, 0, 0);
        send(5, 0, 65535, 1);
        send(1, 1, 1, 0);
        expect_out(3, 3, 3, 2, 0, 0);
        send(2, 2, 2, 1);
        wait_drain();

        // Seven rows without last: force-close at six, row seven opens a new group
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) expect_out(21, 210, 2100, 6, 1, 0);
            send(i, 10 * i, 100 * i, 0);
        end
        send(7, 70, 700, 0);
        expect_out(8, 71, 701, 2, 0, 0);
        send(1, 1, 1, 1);
        wait_drain();

        // Column overflow
        send(65535, 1, 0, 0);
`ifdef ROW_ACCUM_SAT_EN
        expect_out(65535, 2, 0, 2, 0, 1);
`else
        expect_out(0, 2, 0, 2, 0, 0);
`endif
        send(1, 1, 0, 1);
        wait_drain();

        // Backpressure for five cycles
        out_ready = 1'b0;
        send(10, 20, 30, 0);
        expect_out(11, 21, 31, 2, 0, 0);
        send(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_row0", out_row[0], 11);
            check("bp_row2", out_row[2], 31);
            check("bp_count", out_count, 2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_queue_empty", sb.size(), 0);

        // Asynchronous reset mid-group discards the partial sum
        send(3, 3, 3, 0);
        send(4, 4, 4, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        #10;
        rst_n = 1'b1;
        expect_out(9, 8, 7, 1, 0, 0);
        send(9, 8, 7, 1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/row_accumulator.md
# row_accumulator

Sequential, parametrised row aggregator for the GCN adjacency stage. It accepts a stream of FM×WM product rows (one row of WEIGHT_COLS dot products per beat), sums every row of a group element-wise, and emits one aggregated row per group over a valid/ready handshake. It sits between the feature×weight product engine and the output memory write path, and generalises the fixed two-row, three-column combinational add to N rows and any column count.

## Interface
- WEIGHT_COLS, 3, columns per row (≥1)
- DOT_PROD_WIDTH, 16, unsigned width of each column element
- MAX_ROWS, 6, maximum rows per group (adjacency fan-in limit, ≥1)
- COUNT_WIDTH, $clog2(MAX_ROWS+1), width of the row counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  block can accept a row
- in_last  in  1  qualifies the accepted row as the final row of its group
- in_row  in  [DOT_PROD_WIDTH-1:0] x [0:WEIGHT_COLS-1]  input product row
- out_valid  out  1  aggregated row valid
- out_ready  in  1  downstream accepts the aggregated row
- out_row  out  [DOT_PROD_WIDTH-1:0] x [0:WEIGHT_COLS-1]  aggregated row
- out_count  out  COUNT_WIDTH  rows summed into out_row
- out_trunc  out  1  group was force-closed at MAX_ROWS without in_last
- out_ovf  out  1  at least one column overflowed (saturation build only; else 0)

## Operation
- FSM states: IDLE (no partial sum), ACCUM (partial sum held), HOLD (result waiting for downstream).
- Accept = in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- IDLE + accept: accumulator loads in_row (no add), count = 1; next state HOLD if closing, else ACCUM.
- ACCUM + accept: accumulator[c] += in_row[c] for every column; count += 1; next HOLD if closing, else stay.
- Closing beat: in_last = 1, or count after this beat equals MAX_ROWS. If closed by MAX_ROWS with in_last = 0, out_trunc = 1; the next accepted row starts a new group.
- HOLD: out_valid = 1; out_row, out_count, out_trunc, out_ovf stable until out_valid && out_ready; then return to IDLE, clearing the accumulator, count and flags.
- Arithmetic: unsigned, DOT_PROD_WIDTH per column; default wrap modulo 2^DOT_PROD_WIDTH.
- in_last on a non-accepted cycle is ignored.

## Timing
- Reset (rst_n low, any state, asynchronous): state IDLE, in_ready 1 after release, out_valid 0, out_row all 0, out_count 0, out_trunc 0, out_ovf 0. Any partial group is discarded.
- Latency: the closing beat is accepted at edge k; out_valid is high from k+1.
- Throughput: a group of N rows occupies N cycles plus at least 1 HOLD cycle; no overlap between groups.
- out_ready held high: HOLD lasts exactly one cycle, and in_ready rises in the following cycle.
- Backpressure: out_ready low holds HOLD indefinitely; outputs must not change.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends only on state.

## Configuration
- ROW_ACCUM_SAT_EN defined: per-column add saturates at 2^DOT_PROD_WIDTH−1; out_ovf is set sticky for the group when any column clips, and is cleared on the output handshake.
- Not defined: wrap-around add; out_ovf is tied to 0.

## Structure
- gcn_pkg: the state enum typedef (IDLE/ACCUM/HOLD) and a shared default for DOT_PROD_WIDTH.
- Sub-module col_adder: one column, a DOT_PROD_WIDTH add with an overflow output and optional saturation under ROW_ACCUM_SAT_EN. The block instantiates it WEIGHT_COLS times in a generate loop.

## Test plan
- 3-row group {1,2,3},{4,5,6},{7,8,9}, last on row 3, out_ready = 1 → out_row {12,15,18}, out_count 3, out_valid exactly one cycle after the third accept.
- Single-row group {5,0,65535} with in_last → out_row {5,0,65535}, count 1; a following group does not include these values.
- 7 rows without in_last, MAX_ROWS = 6 → first output has count 6 and out_trunc 1; row 7 starts a new group with count 1.
- Overflow {65535,1,0}+{1,1,0} → wrap build {0,2,0} with ovf 0; SAT build {65535,2,0} with out_ovf 1.
- out_ready held low 5 cycles in HOLD → in_ready 0 and outputs stable throughout; handshake on cycle 6, then IDLE.
- rst_n asserted mid-group after 2 rows → all outputs 0 immediately; a new 1-row group afterwards yields exactly that row.
